// File: rtl/debounce_sync_if.sv
// debounce_sync_if: bundles the conditioner's data-side signals.
//   sample_en : prescaler tick qualifying counter advance (master -> slave)
//   din       : raw asynchronous channel inputs              (master -> slave)
//   dout      : debounced, synchronised levels               (slave -> master)
//   rise/fall : one-cycle edge pulses per channel            (slave -> master)
//   busy      : some channel has a qualification in progress (slave -> master)
interface debounce_sync_if #(
    parameter int WIDTH = 4
) ();
    logic             sample_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             busy;

    modport master (
        output sample_en, din,
        input  dout, rise, fall, busy
    );

    modport slave (
        input  sample_en, din,
        output dout, rise, fall, busy
    );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: multi-channel synchroniser + debouncer.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : debounce_sync_if slave (sample_en, din in; dout, rise, fall, busy out)
// Each channel passes through SYNC_STAGES flops, then must present a value
// different from dout on STABLE_CYCLES consecutive sample_en edges before
// dout takes it. One matching sample restarts the qualification.
module debounce_sync #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            reset,
    debounce_sync_if.slave  bus
);
    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] active;

    // Synchroniser chain runs every clock, independent of sample_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.din;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Stability counters, debounced levels and edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            if (bus.sample_en) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (sync_out[i] == dout_q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == LAST) begin
                        dout_q[i] <= sync_out[i];
                        rise_q[i] <= sync_out[i];
                        fall_q[i] <= ~sync_out[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            active[i] = (cnt[i] != '0);
        end
    end

    assign bus.busy = |active;
    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a behavioural model.
module tb_debounce_sync;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passes = 0;
    int   total = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    debounce_sync_if #(.WIDTH(W)) bus ();

    debounce_sync #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: sync_out seen at an edge is din from SS edges earlier (zero after
    // reset); a channel adopts the new value after SC consecutive
    // enabled samples that differ from its current level.
    bit [W-1:0] m_dout, m_rise, m_fall;
    int         m_run [W];
    bit [W-1:0] m_q [$];

    always @(posedge clk or posedge reset) begin
        bit [W-1:0] s;
        if (reset) begin
            m_dout = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_q = {};
            for (int i = 0; i < SS; i++) m_q.push_back('0);
        end else begin
            s = m_q.pop_front();
            m_q.push_back(bus.din);
            m_rise = '0; m_fall = '0;
            if (bus.sample_en) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] == m_dout[i]) m_run[i] = 0;
                    else if (m_run[i] + 1 == SC) begin
                        m_dout[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                        m_run[i] = 0;
                    end else m_run[i] = m_run[i] + 1;
                end
            end
        end
    end

    function automatic bit m_busy();
        for (int i = 0; i < W; i++) if (m_run[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_dout", 32'(bus.dout), 32'(m_dout));
            check("model_rise", 32'(bus.rise), 32'(m_rise));
            check("model_fall", 32'(bus.fall), 32'(m_fall));
            check("model_busy", 32'(bus.busy), 32'(m_busy()));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("reset_dout", 32'(bus.dout), 0);
        check("reset_busy", 32'(bus.busy), 0);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.din = '0;
        bus.sample_en = 1'b1;
        #1 reset = 1'b1;
        #12;
        started = 1;
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_rise", 32'(bus.rise), 0);
        check("rst_fall", 32'(bus.fall), 0);
        check("rst_busy", 32'(bus.busy), 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // 1: single rise, 6-edge latency, busy over edges 3..5
        bus.din = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t1_dout0", 32'(bus.dout[0]), 32'(k >= 6));
            check("t1_rise0", 32'(bus.rise[0]), 32'(k == 6));
            check("t1_fall",  32'(bus.fall), 0);
            check("t1_busy",  32'(bus.busy), 32'(k >= 3 && k <= 5));
        end

        // 2: 3-cycle glitch on channel 1 is rejected
        bus.din = 4'b0011;
        repeat (3) step();
        bus.din = 4'b0001;
        repeat (6) step();
        check("t2_dout", 32'(bus.dout), 32'h1);
        check("t2_busy", 32'(bus.busy), 0);

        // 3: bounce on channel 2, rises 6 edges after the last 0->1 sample
        bus.din = 4'b0101; step();
        bus.din = 4'b0001; step();
        bus.din = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t3_dout2", 32'(bus.dout[2]), 32'(k >= 6));
            check("t3_rise2", 32'(bus.rise[2]), 32'(k == 6));
        end

        // 4: sample_en one edge in three; qualifying edges are 3,6,9,12
        bus.din = 4'b1101;
        for (int k = 1; k <= 14; k++) begin
            bus.sample_en = (k % 3 == 0);
            step();
            check("t4_dout3", 32'(bus.dout[3]), 32'(k >= 12));
            check("t4_rise3", 32'(bus.rise[3]), 32'(k == 12));
        end
        bus.sample_en = 1'b1;

        // 5: reset mid-count, then a full requalification with no release pulse
        do_reset();
        bus.din = 4'b0000;
        repeat (3) step();
        bus.din = 4'b0001;
        repeat (4) step();
        check("t5_busy_pre", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("t5_dout", 32'(bus.dout), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_rise", 32'(bus.rise), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t5_dout0", 32'(bus.dout[0]), 32'(k >= 6));
            check("t5_rise0", 32'(bus.rise[0]), 32'(k == 6));
        end

        // 6: all channels together
        do_reset();
        bus.din = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t6_rise", 32'(bus.rise), (k == 6) ? 32'hF : 32'h0);
        end
        bus.din = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t6_fall", 32'(bus.fall), (k == 6) ? 32'hF : 32'h0);
            check("t6_dout", 32'(bus.dout), (k >= 6) ? 32'h0 : 32'hF);
        end

        // randomized phase: sparse toggles, random sample_en, rare resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 9) == 0) bus.din[i] = ~bus.din[i];
            bus.sample_en = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Multi-channel input conditioner in front of the register primitives (enable-DFF, T-FF, N-bit DFF bank).
- Takes raw asynchronous inputs (buttons, switches, external strobes) and synchronises them into clk.
- Filters bounce/glitches with a per-channel stability counter.
- Emits clean levels plus single-cycle rise/fall pulses, used directly as en/t inputs of downstream flops.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, depth of the synchroniser flop chain per channel (>=2).
- STABLE_CYCLES, 50000, consecutive qualifying samples of a new value required before dout changes (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies stability-counter advance (prescaler tick); tie high for per-clock sampling.
- din  input  WIDTH  raw asynchronous inputs.
- dout  output  WIDTH  debounced, synchronised levels.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1->0.
- busy  output  1  OR over channels of "count in progress" (counter nonzero).

Behaviour:
Reset (asynchronous, any time, including mid-count):
- All synchroniser flops, dout, rise, fall, counters and busy clear to 0 immediately.
- Pulses do not fire on reset deassertion.
- din held high through reset yields dout=1 only after a full qualification.

Synchroniser:
- Per channel, SYNC_STAGES flops in series; sync_out[i] is the last stage.
- Chain advances every clk edge regardless of sample_en.

Per-channel counter:
- Width clog2(STABLE_CYCLES+1).
- On an edge with sample_en=1 and sync_out==dout: counter <= 0.
- On an edge with sample_en=1 and sync_out!=dout and counter==STABLE_CYCLES-1:
  - dout <= sync_out; counter <= 0.
  - rise or fall asserted in the same registered update.
- On an edge with sample_en=1 and sync_out!=dout otherwise: counter increments.
- On an edge with sample_en=0: counter and dout hold.
- A single matching sample aborts the qualification: counter to 0, no partial credit.

Latency (sample_en=1 throughout):
- din changes and stays stable before edge E1 (the first edge that samples it).
- dout changes after edge number SYNC_STAGES+STABLE_CYCLES, counting E1 as 1.
- Defaults scaled to SYNC_STAGES=2, STABLE_CYCLES=4: 6 edges.
- STABLE_CYCLES=1: dout follows sync_out with one extra edge.

Pulses:
- rise[i]/fall[i] high for exactly one clk cycle, coincident with the first cycle of the new dout value.
- Low in all other cycles.
- rise and fall are never both high on the same channel.

Other:
- busy is combinational OR of (counter!=0) across channels; reset value 0.
- Channels are fully independent; simultaneous qualification on several channels yields simultaneous pulses.
- No counter wrap: the counter never exceeds STABLE_CYCLES-1.

Test Plan:
1. WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4, sample_en=1; din[0] 0->1 before edge E1 -> dout[0]=1 after edge 6; rise[0]=1 for exactly that cycle; fall=0; busy high from edge 3 through edge 5.
2. Glitch: din[1] high for 3 cycles then low -> dout[1] stays 0; no rise/fall; counter returns to 0, busy drops.
3. Bounce: din[2] toggles 1,0,1,1,1,1,1… -> dout[2] rises exactly 6 edges after the final 0->1 sample; single rise pulse.
4. sample_en high one cycle in three, din[3] 0->1 -> dout[3] changes only after 4 qualifying sample_en edges following sync; counter frozen on sample_en=0 edges.
5. Reset mid-count: assert reset when counter=2 with din[0]=1 -> dout, rise, fall, busy 0 immediately; after release, a full 6-edge qualification is needed before dout[0]=1; no pulse at release.
6. Simultaneous: din=4'b1111 from 0 -> all dout bits rise on the same edge, rise=4'b1111 for one cycle; then din=0 -> fall=4'b1111 one cycle, 6 edges later.
